// File: rtl/comp_decomp_arbiter_pkg.sv
// Shared types for the compression/decompression arbiter.
//   cmd_e       : engine command encoding
//   rsp_e       : engine response/status encoding
//   arb_state_e : scheduler FSM states
//   DEF_*       : default widths used by the arbiter and its interface
package comp_decomp_pkg;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_COMP   = 2'b01,
    CMD_DECOMP = 2'b10,
    CMD_INV    = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    RSP_NONE   = 2'b00,
    RSP_COMP   = 2'b01,
    RSP_DECOMP = 2'b10,
    RSP_ERR    = 2'b11
  } rsp_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10
  } arb_state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 80;
  localparam int DEF_CODE_W    = 8;
  localparam int DEF_ERR_CNT_W = 16;

endpackage

// File: rtl/comp_decomp_arbiter_if.sv
// Requester-side bus of the arbiter: flattened per-requester request lanes
// (slice i of each vector belongs to requester i) and the shared response.
//   master : requester side (drives requests, receives grants/responses)
//   slave  : arbiter side
interface comp_decomp_arbiter_if #(
  parameter int NUM_REQ = comp_decomp_pkg::DEF_NUM_REQ,
  parameter int DATA_W  = comp_decomp_pkg::DEF_DATA_W,
  parameter int CODE_W  = comp_decomp_pkg::DEF_CODE_W
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [2*NUM_REQ-1:0]      req_cmd;
  logic [DATA_W*NUM_REQ-1:0] req_data;
  logic [CODE_W*NUM_REQ-1:0] req_code;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [1:0]                rsp_status;
  logic [CODE_W-1:0]         rsp_code;
  logic [DATA_W-1:0]         rsp_data;

  modport master (
    output req_valid, req_cmd, req_data, req_code,
    input  req_ready, rsp_valid, rsp_status, rsp_code, rsp_data
  );

  modport slave (
    input  req_valid, req_cmd, req_data, req_code,
    output req_ready, rsp_valid, rsp_status, rsp_code, rsp_data
  );
endinterface

// File: rtl/comp_decomp_arbiter_rr.sv
// Round-robin grant logic.
//   clk, reset : clock, async active-high reset
//   req        : per-requester valid
//   en         : grants allowed this cycle
//   accept     : a grant was taken; advance pointer past the winner
//   gnt        : one-hot grant (first valid at or above the pointer, wrapping)
//   gnt_idx    : binary index of gnt
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic               accept,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_q) + k) % NUM_REQ;
      if (en && !found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept)
      ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/comp_decomp_arbiter.sv
// Shares one compression/decompression engine between NUM_REQ requesters.
// One transaction at a time: grant in IDLE, drive the engine for one cycle
// in ISSUE, register the engine result in CAPTURE and pulse rsp_valid to
// the originator. Error responses are counted with saturation.
//   clk, reset           : clock, async active-high reset
//   bus                  : requester bus (slave side)
//   eng_command/data_in/compressed_in      : engine command outputs
//   eng_compressed_out/decompressed_out/response : engine results
//   busy                 : high in ISSUE and CAPTURE
//   err_count            : saturating count of RSP_ERR responses
module comp_decomp_arbiter
  import comp_decomp_pkg::*;
#(
  parameter  int NUM_REQ   = DEF_NUM_REQ,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int CODE_W    = DEF_CODE_W,
  parameter  int ERR_CNT_W = DEF_ERR_CNT_W,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  comp_decomp_arbiter_if.slave bus,
  output logic [1:0]           eng_command,
  output logic [DATA_W-1:0]    eng_data_in,
  output logic [CODE_W-1:0]    eng_compressed_in,
  input  logic [CODE_W-1:0]    eng_compressed_out,
  input  logic [DATA_W-1:0]    eng_decompressed_out,
  input  logic [1:0]           eng_response,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     id_q, id_d;
  cmd_e                 eng_cmd_q, eng_cmd_d;
  logic [DATA_W-1:0]    eng_data_q, eng_data_d;
  logic [CODE_W-1:0]    eng_code_q, eng_code_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [1:0]           rsp_status_q, rsp_status_d;
  logic [CODE_W-1:0]    rsp_code_q, rsp_code_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 busy_q, busy_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [NUM_REQ-1:0]   gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (bus.req_valid),
    .en      (state_q == ST_IDLE),
    .accept  (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // gnt is only ever set on a valid lane, so any grant is a handshake.
  assign accept = |gnt;

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    eng_cmd_d    = CMD_NOP;
    eng_data_d   = eng_data_q;
    eng_code_d   = eng_code_q;
    rsp_valid_d  = '0;
    rsp_status_d = rsp_status_q;
    rsp_code_d   = rsp_code_q;
    rsp_data_d   = rsp_data_q;
    busy_d       = busy_q;
    err_cnt_d    = err_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // Payload goes straight into the engine-facing registers so it
          // appears on the engine the cycle after the handshake.
          id_d       = gnt_idx;
          eng_cmd_d  = cmd_e'(bus.req_cmd[2*int'(gnt_idx) +: 2]);
          eng_data_d = bus.req_data[DATA_W*int'(gnt_idx) +: DATA_W];
          eng_code_d = bus.req_code[CODE_W*int'(gnt_idx) +: CODE_W];
          busy_d     = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        rsp_valid_d[id_q] = 1'b1;
        rsp_status_d      = eng_response;
        rsp_code_d        = eng_compressed_out;
        rsp_data_d        = eng_decompressed_out;
        if (eng_response == RSP_ERR && err_cnt_q != '1)
          err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      id_q         <= '0;
      eng_cmd_q    <= CMD_NOP;
      eng_data_q   <= '0;
      eng_code_q   <= '0;
      rsp_valid_q  <= '0;
      rsp_status_q <= '0;
      rsp_code_q   <= '0;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      eng_cmd_q    <= eng_cmd_d;
      eng_data_q   <= eng_data_d;
      eng_code_q   <= eng_code_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_code_q   <= rsp_code_d;
      rsp_data_q   <= rsp_data_d;
      busy_q       <= busy_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.req_ready     = gnt;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_status    = rsp_status_q;
  assign bus.rsp_code      = rsp_code_q;
  assign bus.rsp_data      = rsp_data_q;
  assign eng_command       = eng_cmd_q;
  assign eng_data_in       = eng_data_q;
  assign eng_compressed_in = eng_code_q;
  assign busy              = busy_q;
  assign err_count         = err_cnt_q;

endmodule

// File: tb/tb_comp_decomp_arbiter.sv
// Directed then randomized bench. A small dictionary engine model drives the
// engine inputs; a transaction-level model (pending requests, rr pointer,
// cycles since the last handshake, a queue dictionary) predicts every output
// each cycle. err_count is built narrow so saturation is reachable quickly.
module tb_comp_decomp_arbiter;
  localparam int NR = 4, DW = 80, CW = 8, EW = 4;
  localparam int DICT = 1 << CW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  comp_decomp_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .CODE_W(CW)) bus ();
  logic [1:0]    eng_command, eng_response;
  logic [DW-1:0] eng_data_in, eng_decompressed_out;
  logic [CW-1:0] eng_compressed_in, eng_compressed_out;
  logic          busy;
  logic [EW-1:0] err_count;

  comp_decomp_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .CODE_W(CW), .ERR_CNT_W(EW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .eng_command(eng_command), .eng_data_in(eng_data_in),
    .eng_compressed_in(eng_compressed_in), .eng_compressed_out(eng_compressed_out),
    .eng_decompressed_out(eng_decompressed_out), .eng_response(eng_response),
    .busy(busy), .err_count(err_count)
  );

  // Engine: registered result of whatever command is presented each cycle.
  logic [DW-1:0] eng_dict [DICT];
  int eng_n;
  always @(posedge clk or posedge reset) begin : engine
    int hit;
    if (reset) begin
      eng_n = 0;
      eng_response <= 2'b00; eng_compressed_out <= '0; eng_decompressed_out <= '0;
    end else begin
      eng_response <= 2'b00; eng_compressed_out <= '0; eng_decompressed_out <= '0;
      case (eng_command)
        2'b01: begin
          hit = -1;
          for (int i = 0; i < eng_n; i++) if (hit < 0 && eng_dict[i] == eng_data_in) hit = i;
          if (hit < 0 && eng_n < DICT) begin eng_dict[eng_n] = eng_data_in; hit = eng_n; eng_n++; end
          if (hit < 0) eng_response <= 2'b11;
          else begin eng_response <= 2'b01; eng_compressed_out <= CW'(hit); end
        end
        2'b10: begin
          if (int'(eng_compressed_in) < eng_n) begin
            eng_response <= 2'b10; eng_decompressed_out <= eng_dict[eng_compressed_in];
          end else eng_response <= 2'b11;
        end
        2'b11: eng_response <= 2'b11;
        default: ;
      endcase
    end
  end

  // ---------------- reference model ----------------
  int checks = 0, errors = 0;
  bit            pend [NR];
  logic [1:0]    pcmd [NR];
  logic [DW-1:0] pdata[NR];
  logic [CW-1:0] pcode[NR];
  logic [DW-1:0] ref_dict[$];
  int ptr, age, fid, xerr, cyc;
  logic [1:0]    fcmd, nst, xst;
  logic [CW-1:0] ncode, xcode, xeng_code;
  logic [DW-1:0] ndata, xdata, xeng_data;
  int glog[$], gcyc[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_exec(input logic [1:0] c, input logic [DW-1:0] d, input logic [CW-1:0] k,
                          output logic [1:0] st, output logic [CW-1:0] oc, output logic [DW-1:0] od);
    int f;
    st = 2'b00; oc = '0; od = '0;
    case (c)
      2'b01: begin
        f = -1;
        foreach (ref_dict[i]) if (f < 0 && ref_dict[i] == d) f = i;
        if (f < 0 && ref_dict.size() < DICT) begin ref_dict.push_back(d); f = ref_dict.size() - 1; end
        if (f < 0) st = 2'b11; else begin st = 2'b01; oc = CW'(f); end
      end
      2'b10: if (int'(k) < ref_dict.size()) begin st = 2'b10; od = ref_dict[k]; end else st = 2'b11;
      2'b11: st = 2'b11;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    ptr = 0; age = -1; fid = 0; xerr = 0; fcmd = 0;
    xst = 0; xcode = 0; xdata = 0; xeng_code = 0; xeng_data = 0;
    nst = 0; ncode = 0; ndata = 0;
    ref_dict.delete();
    for (int i = 0; i < NR; i++) begin pend[i] = 0; pcmd[i] = 0; pdata[i] = 0; pcode[i] = 0; end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]            = pend[i];
      bus.req_cmd[2*i +: 2]       = pcmd[i];
      bus.req_data[DW*i +: DW]    = pdata[i];
      bus.req_code[CW*i +: CW]    = pcode[i];
    end
  endtask

  task automatic post(input int i, input logic [1:0] c, input logic [DW-1:0] d, input logic [CW-1:0] k);
    pend[i] = 1; pcmd[i] = c; pdata[i] = d; pcode[i] = k;
  endtask

  // One clock cycle: optional random traffic, drive, predict, compare.
  task automatic cycle(input bit rnd);
    int g, j;
    logic [NR-1:0] xr, xv;
    @(negedge clk);
    if (rnd)
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0)
          post(i, 2'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0) ? {16'($urandom), $urandom, $urandom} : DW'($urandom_range(0, 20)),
               CW'($urandom_range(0, ref_dict.size())));
        else if (pend[i] && $urandom_range(0, 15) == 0)
          pend[i] = 0;
      end
    drive();
    #1;
    cyc++;
    if (age >= 0) age++;
    if (age == 3) begin
      xst = nst; xcode = ncode; xdata = ndata;
      if (nst == 2'b11 && xerr < (1 << EW) - 1) xerr++;
    end
    g = -1;
    if (age < 0 || age == 3)
      for (int k = 0; k < NR; k++) begin
        j = (ptr + k) % NR;
        if (g < 0 && pend[j]) g = j;
      end
    xr = (g >= 0) ? NR'(1 << g) : '0;
    xv = (age == 3) ? NR'(1 << fid) : '0;
    chk("req_ready", bus.req_ready, xr);
    chk("rsp_valid", bus.rsp_valid, xv);
    chk("rsp_status", bus.rsp_status, xst);
    chk("rsp_code", bus.rsp_code, xcode);
    chk("rsp_data", bus.rsp_data, xdata);
    chk("eng_command", eng_command, (age == 1) ? fcmd : 2'b00);
    chk("eng_data_in", eng_data_in, xeng_data);
    chk("eng_compressed_in", eng_compressed_in, xeng_code);
    chk("busy", busy, (age == 1 || age == 2));
    chk("err_count", err_count, xerr);
    if (age == 3) age = -1;
    if (g >= 0) begin
      ref_exec(pcmd[g], pdata[g], pcode[g], nst, ncode, ndata);
      fid = g; fcmd = pcmd[g]; xeng_data = pdata[g]; xeng_code = pcode[g];
      pend[g] = 0; ptr = (g + 1) % NR; age = 0;
      glog.push_back(g); gcyc.push_back(cyc);
    end
  endtask

  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) cycle(rnd);
  endtask

  // Reset issued immediately (mid-cycle) and checked while asserted.
  task automatic reset_now();
    for (int i = 0; i < NR; i++) pend[i] = 0;
    drive();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_req_ready", bus.req_ready, '0);
    chk("rst_rsp_valid", bus.rsp_valid, '0);
    chk("rst_rsp_status", bus.rsp_status, '0);
    chk("rst_rsp_code", bus.rsp_code, '0);
    chk("rst_rsp_data", bus.rsp_data, '0);
    chk("rst_eng_command", eng_command, '0);
    chk("rst_eng_data_in", eng_data_in, '0);
    chk("rst_eng_compressed_in", eng_compressed_in, '0);
    chk("rst_busy", busy, '0);
    chk("rst_err_count", err_count, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    bus.req_valid = '0; bus.req_cmd = '0; bus.req_data = '0; bus.req_code = '0;
    reset_now();

    // T1: compress 0x1234 from req0 -> code 0
    post(0, 2'b01, 80'h1234, 8'h0);
    run(4, 0);
    chk("t1_rsp_valid", bus.rsp_valid, 4'b0001);
    chk("t1_status", bus.rsp_status, 2'b01);
    chk("t1_code", bus.rsp_code, 8'h00);

    // T2: same data from req2 hits entry 0; new data from req3 gets code 1
    post(2, 2'b01, 80'h1234, 8'h0);
    run(4, 0);
    chk("t2_rsp_valid", bus.rsp_valid, 4'b0100);
    chk("t2_code", bus.rsp_code, 8'h00);
    post(3, 2'b01, 80'h55, 8'h0);
    run(4, 0);
    chk("t2_new_code", bus.rsp_code, 8'h01);

    // T4: decompress code 0 from req1
    post(1, 2'b10, 80'h0, 8'h00);
    run(4, 0);
    chk("t4_status", bus.rsp_status, 2'b10);
    chk("t4_data", bus.rsp_data, 80'h1234);

    // T5: invalid command counts as error, then saturates
    post(3, 2'b11, 80'h0, 8'h0);
    run(4, 0);
    chk("t5_status", bus.rsp_status, 2'b11);
    chk("t5_err_one", err_count, 4'd1);
    for (int n = 0; n < 15; n++) begin post(3, 2'b11, 80'h0, 8'h0); run(4, 0); end
    chk("t5_err_sat", err_count, 4'hF);

    // T6: reset while in CAPTURE drops the transaction
    post(1, 2'b01, 80'h77, 8'h0);
    run(3, 0);
    chk("t6_busy_before", busy, 1'b1);
    reset_now();
    run(2, 0);

    // T3: all four valid with pointer 0 -> 0,1,2,3 every 3 cycles
    glog.delete(); gcyc.delete();
    for (int i = 0; i < NR; i++) post(i, 2'b01, DW'(80'h100 + i), 8'h0);
    run(13, 0);
    chk("t3_grants", DW'(glog.size()), DW'(4));
    for (int i = 0; i < NR && i < glog.size(); i++) begin
      chk("t3_order", DW'(glog[i]), DW'(i));
      if (i > 0) chk("t3_spacing", DW'(gcyc[i] - gcyc[i-1]), DW'(3));
    end

    // Random traffic
    run(600, 1);
    for (int i = 0; i < NR; i++) pend[i] = 0;
    run(4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comp_decomp_arbiter.md
Name: comp_decomp_arbiter

Overview:
Round-robin scheduler that shares one compression_decompression engine between NUM_REQ requesters. It accepts one request at a time over a valid/ready handshake, drives the engine command for exactly one cycle, captures the engine response and returns it to the originating requester. It also keeps a saturating count of error responses. It sits between the client interfaces and the single engine instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 80, uncompressed word width
CODE_W, 8, compressed code width
ERR_CNT_W, 16, width of the error counter

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot grant; a handshake completes when valid&ready at posedge
req_cmd  in  2*NUM_REQ  per-requester command, slice i = [2i+1:2i]
req_data  in  DATA_W*NUM_REQ  per-requester data to compress
req_code  in  CODE_W*NUM_REQ  per-requester code to decompress
rsp_valid  out  NUM_REQ  one-cycle pulse to the originating requester
rsp_status  out  2  engine response for the returned transaction
rsp_code  out  CODE_W  engine compressed_out
rsp_data  out  DATA_W  engine decompressed_out
eng_command  out  2  to engine command
eng_data_in  out  DATA_W  to engine data_in
eng_compressed_in  out  CODE_W  to engine compressed_in
eng_compressed_out  in  CODE_W  from engine
eng_decompressed_out  in  DATA_W  from engine
eng_response  in  2  from engine
busy  out  1  high in ISSUE and CAPTURE
err_count  out  ERR_CNT_W  saturating count of responses with status 11

Behaviour:
- Reset values: state IDLE; rr pointer 0; req_ready 0; rsp_valid 0; rsp_status/rsp_code/rsp_data 0; eng_command 00 (NOP); eng_data_in/eng_compressed_in 0; busy 0; err_count 0.
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE:
  - req_ready is combinational and one-hot: it selects the first valid requester searching from the rr pointer upward with wrap.
  - No valid requester gives req_ready 0.
  - On a handshake with requester i, latch id, cmd, data and code; set pointer = (i+1) mod NUM_REQ; go to ISSUE.
- ISSUE (1 cycle):
  - eng_command, eng_data_in and eng_compressed_in are driven from latched values.
  - Go to CAPTURE.
- CAPTURE (1 cycle):
  - eng_command = NOP; eng_data_in and eng_compressed_in hold their values.
  - At the posedge: register rsp_status, rsp_code and rsp_data from the engine; assert rsp_valid[id]; go to IDLE.
  - If the captured status is 11 and err_count has not saturated, increment err_count.
- Latency: handshake in cycle N, command on the engine in cycle N+1, rsp_valid high in cycle N+3.
  - A new grant is possible in cycle N+3, so the sustained rate is 1 transaction per 3 cycles.
- rsp_valid has no back-pressure; requesters must accept it.
- rsp_status/rsp_code/rsp_data hold until the next capture.
- Requesters must hold req_valid and their payload stable until granted.
- Commands are forwarded unmodified:
  - 00 returns status 00.
  - 11 returns status 11 and counts as an error.
- eng_command is NOP in every state except ISSUE.
- req_ready is 0 outside IDLE.
- A requester deasserting valid before grant is simply skipped.
- Reset mid-transaction: the in-flight request is dropped, no rsp_valid is emitted, and all registers return to reset values on the same cycle reset asserts. The engine shares reset, so its dictionary clears too.
- err_count saturates at all-ones; it never wraps.

Decomposition:
- Package comp_decomp_pkg:
  - cmd_e (CMD_NOP=00, CMD_COMP=01, CMD_DECOMP=10, CMD_INV=11)
  - rsp_e (RSP_NONE=00, RSP_COMP=01, RSP_DECOMP=10, RSP_ERR=11)
  - DATA_W/CODE_W defaults
  - arb_state_e
- Sub-module rr_arbiter (NUM_REQ): pointer register plus one-hot grant logic, pointer advanced by an accept strobe.

Test Plan:
1. After reset, req0 compresses 80'h1234 -> eng_command=01 only in cycle N+1; rsp_valid[0] at N+3, status 01, code 0.
2. req2 then compresses 80'h1234 -> status 01, code 0; no new dictionary entry (a follow-up compress of 80'h55 returns code 1).
3. All four requesters valid from cycle N with pointer 0 -> grants to 0,1,2,3 at N, N+3, N+6, N+9; each rsp_valid only on its own bit.
4. req1 decompresses code 0 after test 1 -> status 10, rsp_data 80'h1234.
5. req3 issues cmd 11 -> status 11, err_count 0->1. With err_count forced to FFFF -> stays FFFF.
6. Reset asserted during CAPTURE -> no rsp_valid, all outputs 0, state IDLE, next grant starts from req0.
